dma_peripheral_endpoint: RTL and testbench

//  Peripheral-side end of the 8237-style DMA handshake: raises DREQ, answers DACK-qualified IOR/IOW strobes

---
 rtl/dma_peripheral_endpoint.sv | 176 +++++++++++++++++
 tb/tb_dma_peripheral_endpoint.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_peripheral_endpoint.sv
// Peripheral end of an 8237-style DMA channel: drives DREQ, answers DACK-qualified
// IOR/IOW cycles and buffers bytes between the system bus and local streams via a FIFO.
module dma_peripheral_endpoint #(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mode,
  input  logic               start,
  input  logic               clear,
  output logic               dma_request,
  input  logic               dma_acknowledge_n,
  input  logic               io_read_n,
  input  logic               io_write_n,
  input  logic               terminal_count_n,
  input  logic [7:0]         data_bus_in,
  output logic [7:0]         data_bus_out,
  output logic               data_bus_out_en,
  input  logic               src_valid,
  input  logic [7:0]         src_data,
  output logic               src_ready,
  output logic               snk_valid,
  output logic [7:0]         snk_data,
  input  logic               snk_ready,
  output logic               done,
  output logic               underrun,
  output logic               overrun,
  output logic [COUNT_W-1:0] byte_count
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
  logic [FIFO_AW:0]   count;
  logic               mode_latched;
  logic               dack_q, ior_q, iow_q;
  logic               tc_latched;
  logic [7:0]         wdata_q;

  logic dack, empty, full;
  logic rd_edge, wr_edge, complete;
  logic bus_pop, bus_push, src_push, snk_pop, push, pop;
  logic underrun_ev, overrun_ev, tc_set, tc_finish;
  logic [7:0] wr_data;
  logic in_flight, dreq_nxt;
  logic [FIFO_AW+1:0] level, need;

  assign dack  = ~dma_acknowledge_n;
  assign empty = (count == '0);
  assign full  = (count == FULL_LVL);

  // A bus transfer completes on the rising strobe edge, only if DACK framed the low phase.
  assign rd_edge  = dack_q & ~ior_q & io_read_n;
  assign wr_edge  = dack_q & ~iow_q & io_write_n;
  assign complete = ~clear & (mode_latched ? wr_edge : rd_edge);

  assign snk_valid = mode_latched & ~clear & ~empty;
  assign snk_data  = mem[rd_ptr];
  assign snk_pop   = snk_valid & snk_ready;

  assign bus_pop     = complete & ~mode_latched & ~empty;
  assign underrun_ev = complete & ~mode_latched & empty;
  assign bus_push    = complete & mode_latched & (~full | snk_pop);
  assign overrun_ev  = complete & mode_latched & full & ~snk_pop;

  // A bus pop in the same cycle frees the slot, so a full FIFO can still accept a source byte.
  assign src_ready = ~mode_latched & ~clear & (~full | bus_pop);
  assign src_push  = src_valid & src_ready;

  assign push    = src_push | bus_push;
  assign pop     = bus_pop | snk_pop;
  assign wr_data = mode_latched ? wdata_q : src_data;

  assign data_bus_out    = empty ? 8'hFF : mem[rd_ptr];
  assign data_bus_out_en = dack & ~io_read_n & ~mode_latched & ~reset;

  assign tc_set    = ~terminal_count_n & dack & (mode_latched ? ~io_write_n : ~io_read_n);
  assign tc_finish = complete & tc_latched & (state == ST_ACTIVE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear)          state_nxt = ST_IDLE;
    else if (start)     state_nxt = ST_ACTIVE;
    else if (tc_finish) state_nxt = ST_DONE;
  end

  // DREQ margin discounts both the byte under DACK and the byte completing this cycle,
  // so the registered request never outruns the FIFO.
  assign in_flight = mode_latched ? bus_push : bus_pop;
  assign level     = mode_latched ? {1'b0, FULL_LVL - count} : {1'b0, count};
  assign need      = {{(FIFO_AW+1){1'b0}}, 1'b1} + {{(FIFO_AW+1){1'b0}}, in_flight}
                   + {{(FIFO_AW+1){1'b0}}, dack};

  always_comb begin
    dreq_nxt = 1'b0;
    if ((state == ST_ACTIVE) && !clear && !tc_finish)
      dreq_nxt = (level >= need);
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dack_q       <= 1'b0;
      ior_q        <= 1'b1;
      iow_q        <= 1'b1;
      wdata_q      <= '0;
      tc_latched   <= 1'b0;
      mode_latched <= 1'b0;
      dma_request  <= 1'b0;
      done         <= 1'b0;
      underrun     <= 1'b0;
      overrun      <= 1'b0;
      byte_count   <= '0;
    end else begin
      dack_q      <= dack;
      ior_q       <= io_read_n;
      iow_q       <= io_write_n;
      dma_request <= dreq_nxt;
      done        <= tc_finish;
      if (dack && !io_write_n) wdata_q <= data_bus_in;

      if (clear || start)          tc_latched <= 1'b0;
      else if (tc_set)             tc_latched <= 1'b1;
      else if (complete || !dack)  tc_latched <= 1'b0;

      if (start && !clear) mode_latched <= mode;

      if (start && !clear)  byte_count <= '0;
      else if (complete)    byte_count <= byte_count + 1'b1;

      if (clear) begin
        underrun <= 1'b0;
        overrun  <= 1'b0;
      end else begin
        if (underrun_ev) underrun <= 1'b1;
        if (overrun_ev)  overrun  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_peripheral_endpoint.sv
// Bench for dma_peripheral_endpoint: random bytes through both directions, checked
// against a queue-based model of the FIFO, counters, flags and channel phase.
module tb_dma_peripheral_endpoint;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0, start = 1'b0, clear = 1'b0;
  logic        dreq;
  logic        dack_n = 1'b1, ior_n = 1'b1, iow_n = 1'b1, tc_n = 1'b1;
  logic [7:0]  dbi = '0, dbo;
  logic        dbo_en;
  logic        src_valid = 1'b0, src_ready;
  logic [7:0]  src_data = '0;
  logic        snk_valid, snk_ready = 1'b0;
  logic [7:0]  snk_data;
  logic        done, underrun, overrun;
  logic [15:0] byte_count;

  always #5 clock = ~clock;

  dma_peripheral_endpoint #(.FIFO_AW(4), .COUNT_W(16)) dut (
    .clock(clock), .reset(reset), .mode(mode), .start(start), .clear(clear),
    .dma_request(dreq), .dma_acknowledge_n(dack_n), .io_read_n(ior_n), .io_write_n(iow_n),
    .terminal_count_n(tc_n), .data_bus_in(dbi), .data_bus_out(dbo), .data_bus_out_en(dbo_en),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
    .done(done), .underrun(underrun), .overrun(overrun), .byte_count(byte_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO contents, channel armed flag, direction, counters, flags.
  logic [7:0]  q[$];
  bit          m_active = 0, m_mode = 0, m_under = 0, m_over = 0;
  int unsigned m_bc = 0;

  function automatic logic exp_dreq();
    return m_active && (m_mode ? (q.size() < 16) : (q.size() > 0));
  endfunction

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
    q.delete(); m_active = 0; m_under = 0; m_over = 0;
  endtask

  task automatic do_start(input bit md);
    mode = md; start = 1'b1; step(); start = 1'b0;
    m_active = 1; m_mode = md; m_bc = 0;
  endtask

  task automatic src_push(input logic [7:0] b);
    src_valid = 1'b1; src_data = b; step(); src_valid = 1'b0;
    if (q.size() < 16) q.push_back(b);
  endtask

  task automatic bus_read(input bit tc, output logic [7:0] d, output logic en);
    dack_n = 1'b0; ior_n = 1'b0; tc_n = !tc;
    #1; d = dbo; en = dbo_en;
    step();
    ior_n = 1'b1; dack_n = 1'b1; tc_n = 1'b1;
    step();
    m_bc++;
    if (q.size() == 0) m_under = 1; else void'(q.pop_front());
    if (tc) m_active = 0;
  endtask

  task automatic bus_write(input bit tc, input logic [7:0] b);
    dack_n = 1'b0; iow_n = 1'b0; dbi = b; tc_n = !tc;
    step();
    iow_n = 1'b1; dack_n = 1'b1; tc_n = 1'b1;
    step();
    m_bc++;
    if (q.size() < 16) q.push_back(b); else m_over = 1;
    if (tc) m_active = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0; step();
    n_cmp++; if (dreq !== 1'b0) begin n_err++; $display("FAIL reset_dreq: got %0b want 0", dreq); end
    n_cmp++; if (dbo_en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %0b want 0", dbo_en); end
    n_cmp++; if (dbo !== 8'hFF) begin n_err++; $display("FAIL reset_dbo: got %h want ff", dbo); end
    n_cmp++; if ({done, underrun, overrun, snk_valid} !== 4'b0) begin n_err++;
      $display("FAIL reset_flags: got %b want 0000", {done, underrun, overrun, snk_valid}); end
    n_cmp++; if (byte_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", byte_count); end
    n_cmp++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL reset_src_ready: got %0b want 1", src_ready); end
  endtask

  task automatic test_mode0_read(input bit use_fixed);
    logic [7:0] tbl [3];
    logic [7:0] d, e;
    logic en;
    int n;
    tbl = '{8'hA1, 8'hB2, 8'hC3};
    n = use_fixed ? 3 : int'($urandom_range(4, 12));
    do_clear();
    for (int i = 0; i < n; i++) src_push(use_fixed ? tbl[i] : 8'($urandom));
    step();
    do_start(1'b0);
    n_cmp++; if (dreq !== 1'b0) begin n_err++; $display("FAIL m0_dreq_lat1: got %0b want 0", dreq); end
    step();
    n_cmp++; if (dreq !== exp_dreq()) begin n_err++; $display("FAIL m0_dreq_lat2: got %0b want %0b", dreq, exp_dreq()); end
    for (int i = 0; i < n; i++) begin
      e = q[0];
      bus_read(1'b0, d, en);
      n_cmp++; if (d !== e || en !== 1'b1) begin n_err++;
        $display("FAIL m0_read[%0d]: got %h/en%0b want %h/en1", i, d, en, e); end
      n_cmp++; if (dreq !== exp_dreq()) begin n_err++;
        $display("FAIL m0_dreq[%0d]: got %0b want %0b", i, dreq, exp_dreq()); end
    end
    n_cmp++; if (byte_count !== 16'(m_bc) || underrun !== 1'b0) begin n_err++;
      $display("FAIL m0_count: got %0d/u%0b want %0d/u0", byte_count, underrun, m_bc); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, e;
    int n;
    n = int'($urandom_range(4, 12));
    do_clear();
    for (int i = 0; i < n; i++) src_push(8'($urandom));
    do_start(1'b0);
    step();
    dack_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = q[0];
      ior_n = 1'b0; #1; d = dbo;
      step();
      ior_n = 1'b1;
      step();
      void'(q.pop_front()); m_bc++;
      n_cmp++; if (d !== e) begin n_err++; $display("FAIL b2b_read[%0d]: got %h want %h", i, d, e); end
    end
    dack_n = 1'b1;
    step();
    n_cmp++; if (byte_count !== 16'(m_bc) || dreq !== exp_dreq()) begin n_err++;
      $display("FAIL b2b_end: got cnt%0d dreq%0b want cnt%0d dreq%0b", byte_count, dreq, m_bc, exp_dreq()); end
  endtask

  task automatic test_snk_drain();
    snk_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) begin
      n_cmp++; if (snk_valid !== 1'b1 || snk_data !== q[0]) begin n_err++;
        $display("FAIL snk_data[%0d]: got v%0b %h want v1 %h", i, snk_valid, snk_data, q[0]); end
      step();
      void'(q.pop_front());
    end
    snk_ready = 1'b0;
    n_cmp++; if (snk_valid !== 1'b0) begin n_err++; $display("FAIL snk_empty: got %0b want 0", snk_valid); end
  endtask

  task automatic test_mode1_write(input bit use_fixed);
    logic [7:0] tbl [2];
    int k;
    tbl = '{8'h55, 8'hAA};
    k = use_fixed ? 2 : int'($urandom_range(3, 8));
    do_start(1'b1);
    step();
    n_cmp++; if (src_ready !== 1'b0 || dreq !== exp_dreq()) begin n_err++;
      $display("FAIL m1_start: got rdy%0b dreq%0b want rdy0 dreq%0b", src_ready, dreq, exp_dreq()); end
    for (int i = 0; i < k; i++) begin
      bus_write(i == k - 1, use_fixed ? tbl[i] : 8'($urandom));
      n_cmp++; if (done !== (i == k - 1)) begin n_err++;
        $display("FAIL m1_done[%0d]: got %0b want %0b", i, done, (i == k - 1)); end
    end
    n_cmp++; if (dreq !== 1'b0) begin n_err++; $display("FAIL m1_dreq_tc: got %0b want 0", dreq); end
    step();
    n_cmp++; if (done !== 1'b0 || dreq !== 1'b0) begin n_err++;
      $display("FAIL m1_after_done: got done%0b dreq%0b want 0 0", done, dreq); end
    n_cmp++; if (byte_count !== 16'(m_bc) || overrun !== 1'b0) begin n_err++;
      $display("FAIL m1_count: got %0d/o%0b want %0d/o0", byte_count, overrun, m_bc); end
    test_snk_drain();
  endtask

  task automatic test_overrun();
    do_start(1'b1);
    for (int i = 0; i < 17; i++) begin
      bus_write(1'b0, 8'($urandom));
      if (i == 15) begin
        n_cmp++; if (overrun !== 1'b0 || dreq !== 1'b0) begin n_err++;
          $display("FAIL ovr_at16: got o%0b dreq%0b want o0 dreq0", overrun, dreq); end
      end
    end
    n_cmp++; if (overrun !== 1'(m_over) || byte_count !== 16'(m_bc)) begin n_err++;
      $display("FAIL ovr_flag: got o%0b cnt%0d want o%0b cnt%0d", overrun, byte_count, m_over, m_bc); end
    test_snk_drain();
  endtask

  task automatic test_underrun();
    logic [7:0] d;
    logic en;
    do_clear();
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL clr_overrun: got %0b want 0", overrun); end
    do_start(1'b0);
    step();
    bus_read(1'b0, d, en);
    n_cmp++; if (d !== 8'hFF || en !== 1'b1) begin n_err++;
      $display("FAIL udr_bus: got %h/en%0b want ff/en1", d, en); end
    n_cmp++; if (underrun !== 1'(m_under) || dbo !== 8'hFF || src_ready !== 1'b1) begin n_err++;
      $display("FAIL udr_flag: got u%0b dbo%h rdy%0b want u%0b dboff rdy1", underrun, dbo, src_ready, m_under); end
    do_clear();
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL udr_clear: got %0b want 0", underrun); end
  endtask

  task automatic test_abort();
    logic [7:0] d, e;
    logic en;
    do_clear();
    src_push(8'($urandom)); src_push(8'($urandom));
    do_start(1'b0);
    step();
    dack_n = 1'b1; ior_n = 1'b0; #1;
    n_cmp++; if (dbo_en !== 1'b0) begin n_err++; $display("FAIL abort_en_nodack: got %0b want 0", dbo_en); end
    step(); ior_n = 1'b1; step();
    n_cmp++; if (dbo !== q[0] || byte_count !== 16'(m_bc)) begin n_err++;
      $display("FAIL abort_nodack: got %h cnt%0d want %h cnt%0d", dbo, byte_count, q[0], m_bc); end
    dack_n = 1'b0; ior_n = 1'b0; step();
    dack_n = 1'b1; step();
    ior_n = 1'b1; step();
    n_cmp++; if (dbo !== q[0] || byte_count !== 16'(m_bc)) begin n_err++;
      $display("FAIL abort_dack_drop: got %h cnt%0d want %h cnt%0d", dbo, byte_count, q[0], m_bc); end
    dack_n = 1'b0; iow_n = 1'b0; step();
    iow_n = 1'b1; dack_n = 1'b1; step();
    n_cmp++; if (dbo !== q[0] || byte_count !== 16'(m_bc) || {underrun, overrun} !== 2'b00) begin n_err++;
      $display("FAIL abort_wrong_dir: got %h cnt%0d flags%b want %h cnt%0d 00", dbo, byte_count, {underrun, overrun}, q[0], m_bc); end
    e = q[0];
    bus_read(1'b0, d, en);
    n_cmp++; if (d !== e || byte_count !== 16'(m_bc)) begin n_err++;
      $display("FAIL abort_recover: got %h cnt%0d want %h cnt%0d", d, byte_count, e, m_bc); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] d, e, x;
    logic en, rdy;
    do_clear();
    for (int i = 0; i < 16; i++) src_push(8'($urandom));
    n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL sim_full_ready: got %0b want 0", src_ready); end
    do_start(1'b0);
    step();
    e = q[0]; x = 8'($urandom);
    dack_n = 1'b0; ior_n = 1'b0; #1; d = dbo;
    step();
    ior_n = 1'b1; dack_n = 1'b1; src_valid = 1'b1; src_data = x; #1; rdy = src_ready;
    step();
    src_valid = 1'b0;
    void'(q.pop_front()); q.push_back(x); m_bc++;
    n_cmp++; if (d !== e || rdy !== 1'b1) begin n_err++;
      $display("FAIL sim_pop_push: got %h rdy%0b want %h rdy1", d, rdy, e); end
    n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL sim_still_full: got %0b want 0", src_ready); end
    for (int i = 0; i < 16; i++) begin
      e = q[0];
      bus_read(1'b0, d, en);
      n_cmp++; if (d !== e) begin n_err++; $display("FAIL sim_read[%0d]: got %h want %h", i, d, e); end
    end
    n_cmp++; if (dbo !== 8'hFF || byte_count !== 16'(m_bc) || underrun !== 1'b0) begin n_err++;
      $display("FAIL sim_end: got %h cnt%0d u%0b want ff cnt%0d u0", dbo, byte_count, underrun, m_bc); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic en;
    do_clear();
    src_push(8'($urandom)); src_push(8'($urandom)); src_push(8'($urandom));
    do_start(1'b0);
    step();
    bus_read(1'b0, d, en);
    dack_n = 1'b0; ior_n = 1'b0; step();
    reset = 1'b1; step();
    n_cmp++; if ({dreq, dbo_en, done, underrun, overrun, snk_valid} !== 6'b0) begin n_err++;
      $display("FAIL rst_mid_bits: got %b want 000000", {dreq, dbo_en, done, underrun, overrun, snk_valid}); end
    n_cmp++; if (dbo !== 8'hFF || byte_count !== 16'd0 || src_ready !== 1'b1) begin n_err++;
      $display("FAIL rst_mid_vals: got %h cnt%0d rdy%0b want ff cnt0 rdy1", dbo, byte_count, src_ready); end
    ior_n = 1'b1; dack_n = 1'b1; step();
    reset = 1'b0; step(); step();
    q.delete(); m_active = 0; m_mode = 0; m_bc = 0; m_under = 0; m_over = 0;
    n_cmp++; if (dbo !== 8'hFF || byte_count !== 16'(m_bc) || dreq !== exp_dreq()) begin n_err++;
      $display("FAIL rst_mid_after: got %h cnt%0d dreq%0b want ff cnt0 dreq0", dbo, byte_count, dreq); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mode0_read(1'b1);
    test_mode0_read(1'b0);
    test_back_to_back();
    test_mode1_write(1'b1);
    test_mode1_write(1'b0);
    test_overrun();
    test_underrun();
    test_abort();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
